// File: rtl/destination_monitor_if.sv
// Telemetry sample handshake plus monitor verdict outputs.
// master = sensor aggregation / sequencer side, slave = destination_monitor.
interface destination_monitor_if #(
  parameter int unsigned ALT_W = 10
);
  localparam int unsigned SC_W = $clog2(ALT_W + 1);

  logic             sample_valid;
  logic             sample_ready;
  logic [ALT_W-1:0] altitude;
  logic             temp_ok;
  logic             rad_high;
  logic             oxygen_ok;
  logic             life_ok;
  logic             clear_abort;
  logic [1:0]       next_state;
  logic             state_valid;
  logic [ALT_W-1:0] alt_scaled;
  logic [SC_W-1:0]  shift_count;

  modport master (
    output sample_valid, altitude, temp_ok, rad_high, oxygen_ok, life_ok, clear_abort,
    input  sample_ready, next_state, state_valid, alt_scaled, shift_count
  );

  modport slave (
    input  sample_valid, altitude, temp_ok, rad_high, oxygen_ok, life_ok, clear_abort,
    output sample_ready, next_state, state_valid, alt_scaled, shift_count
  );
endinterface

// File: rtl/destination_monitor.sv
// Range-scales altitude by right-shifts, then filters faults over PERSIST samples into NOMINAL/WARN/ABORT.
// Report strobe k+2 edges after acceptance (k = shifts); only accepts a sample while idle.
module destination_monitor #(
  parameter int unsigned     ALT_W       = 10,
  parameter logic [ALT_W-1:0] MAX_ALT    = ALT_W'(768),
  parameter int unsigned     SHIFT_LIMIT = 0,
  parameter int unsigned     PERSIST     = 3
) (
  input  logic               clk,
  input  logic               rst,
  destination_monitor_if.slave mon
);
  localparam int unsigned SC_W = $clog2(ALT_W + 1);
  localparam int unsigned FC_W = $clog2(PERSIST + 1);
  localparam logic [SC_W-1:0] SHIFT_LIM = SC_W'(SHIFT_LIMIT);
  localparam logic [FC_W-1:0] PERSIST_C = FC_W'(PERSIST);

  localparam logic [1:0] NS_NOMINAL = 2'b00;
  localparam logic [1:0] NS_WARN    = 2'b01;
  localparam logic [1:0] NS_ABORT   = 2'b11;

  typedef enum logic [1:0] {IDLE, SCALE, EVAL, REPORT} state_t;

  state_t           state_q, state_d;
  logic [ALT_W-1:0] alt_q;
  logic [SC_W-1:0]  sc_q;
  logic             temp_ok_q, rad_high_q, oxygen_ok_q, life_ok_q;
  logic [FC_W-1:0]  fault_cnt;
  logic             abort_latched;
  logic [1:0]       ns_q;

  logic             accept;
  logic             too_high;
  logic             alt_ok;
  logic             fault;
  logic [FC_W-1:0]  cnt_base;
  logic             latched_base;
  logic [FC_W-1:0]  cnt_upd;
  logic             abort_now;

  assign mon.sample_ready = (state_q == IDLE);
  assign mon.state_valid  = (state_q == REPORT);
  assign mon.next_state   = ns_q;
  assign mon.alt_scaled   = alt_q;
  assign mon.shift_count  = sc_q;

  assign accept   = mon.sample_valid && (state_q == IDLE);
  assign too_high = (alt_q > MAX_ALT);

  // A clear arriving in EVAL must be seen by this evaluation, so fold it in here.
  always_comb begin
    alt_ok       = (sc_q <= SHIFT_LIM);
    fault        = ~alt_ok | ~temp_ok_q | rad_high_q | ~oxygen_ok_q | ~life_ok_q;
    cnt_base     = mon.clear_abort ? '0 : fault_cnt;
    latched_base = mon.clear_abort ? 1'b0 : abort_latched;
    cnt_upd      = '0;
    if (fault) begin
      cnt_upd = (cnt_base == PERSIST_C) ? PERSIST_C : cnt_base + FC_W'(1);
    end
    abort_now    = latched_base || (cnt_upd == PERSIST_C);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SCALE;
      SCALE:   if (!too_high) state_d = EVAL;
      EVAL:    state_d = REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      alt_q         <= '0;
      sc_q          <= '0;
      temp_ok_q     <= 1'b0;
      rad_high_q    <= 1'b0;
      oxygen_ok_q   <= 1'b0;
      life_ok_q     <= 1'b0;
      fault_cnt     <= '0;
      abort_latched <= 1'b0;
      ns_q          <= NS_NOMINAL;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            alt_q       <= mon.altitude;
            sc_q        <= '0;
            temp_ok_q   <= mon.temp_ok;
            rad_high_q  <= mon.rad_high;
            oxygen_ok_q <= mon.oxygen_ok;
            life_ok_q   <= mon.life_ok;
          end
        end
        SCALE: begin
          if (too_high) begin
            alt_q <= alt_q >> 1;
            sc_q  <= sc_q + SC_W'(1);
          end
        end
        EVAL: begin
          fault_cnt <= cnt_upd;
          if (abort_now) begin
            ns_q          <= NS_ABORT;
            abort_latched <= 1'b1;
          end else begin
            abort_latched <= 1'b0;
            ns_q          <= fault ? NS_WARN : NS_NOMINAL;
          end
        end
        default: ;
      endcase
      if (mon.clear_abort && state_q != EVAL) begin
        abort_latched <= 1'b0;
        fault_cnt     <= '0;
        ns_q          <= NS_NOMINAL;
      end
    end
  end
endmodule

// File: doc/destination_monitor.md
Name: destination_monitor

Overview:
- Clocked, parametrised successor to the combinational destination check.
- Accepts one telemetry sample per handshake and range-scales the altitude by iterative right-shift until it is no greater than MAX_ALT.
- Combines the altitude result with the environment flags and applies a persistence filter before declaring abort.
- Sits between the sensor aggregation stage and the mission sequencer; the sequencer consumes next_state when state_valid is high.

Parameters:
ALT_W, 10, altitude width in bits
MAX_ALT, 768 (10'b1100000000), maximum permitted altitude; width ALT_W
SHIFT_LIMIT, 0, maximum shifts still counted as altitude OK
PERSIST, 3, consecutive faulted samples required to abort; legal range >=1

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
sample_valid  in  1  sample present
sample_ready  out  1  block can accept a sample
altitude  in  ALT_W  raw altitude
temp_ok  in  1  temperature within limits
rad_high  in  1  radiation above limit
oxygen_ok  in  1  oxygen within limits
life_ok  in  1  life support nominal
clear_abort  in  1  clears sticky abort and the persistence counter
next_state  out  2  00 NOMINAL, 01 WARN, 11 ABORT (10 never driven)
state_valid  out  1  one-cycle strobe: next_state freshly updated
alt_scaled  out  ALT_W  altitude after scaling
shift_count  out  $clog2(ALT_W+1)  number of shifts applied

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: FSM=IDLE, next_state=00, state_valid=0, alt_scaled=0, shift_count=0, fault_cnt=0, abort_latched=0. sample_ready=1 in the first cycle after reset.
- Reset asserted in any state, including mid-scale, discards the in-flight sample and applies the reset values at that edge.
- FSM states: IDLE, SCALE, EVAL, REPORT. sample_ready = (state==IDLE), combinational.
- IDLE: on sample_valid&&sample_ready, register altitude into alt_scaled, register the four flags, clear shift_count, go to SCALE.
- SCALE, one step per cycle:
  - if alt_scaled > MAX_ALT (unsigned): alt_scaled <= alt_scaled>>1 and shift_count++.
  - else go to EVAL.
  - Always terminates: at most ALT_W shifts, since 0 is never > MAX_ALT.
- EVAL:
  - alt_ok = (shift_count <= SHIFT_LIMIT).
  - fault = ~alt_ok | ~temp_ok | rad_high | ~oxygen_ok | ~life_ok, using the registered flags.
  - If fault: fault_cnt saturating-increments, capped at PERSIST, width $clog2(PERSIST+1). Else: fault_cnt <= 0.
  - Use the updated count: if abort_latched or count==PERSIST, then next_state<=11 and abort_latched<=1; else if fault, next_state<=01; else next_state<=00.
  - Go to REPORT.
- REPORT: state_valid=1 for exactly this cycle, then return to IDLE.
- Latency: acceptance at edge T0 with k shifts gives state_valid high in the cycle after edge T0+k+2. Nominal sample (k=0): 2 edges. Worst case: ALT_W+2 edges. Throughput: one sample per k+4 cycles.
- next_state, alt_scaled and shift_count hold their values between reports; alt_scaled and shift_count change during SCALE.
- ABORT is sticky: it persists across later good samples until clear_abort.
- clear_abort is honoured in any state. At that edge: abort_latched<=0, fault_cnt<=0, next_state<=00.
  - clear_abort in EVAL: the evaluation uses the cleared values.
  - clear_abort simultaneous with acceptance in IDLE: both take effect.
- PERSIST=1: the first faulted sample aborts directly, with no WARN.

Test Plan:
- altitude=500, all flags OK -> shift_count=0, alt_scaled=500, next_state=00; state_valid high in the cycle after edge T0+2; sample_ready=0 for 3 cycles.
- altitude=10'b1101100001 (865), flags OK -> alt_scaled=432, shift_count=1; next_state=01 because SHIFT_LIMIT=0; state_valid after edge T0+3.
- Override MAX_ALT=100, SHIFT_LIMIT=4; altitude=1000 -> alt_scaled=62, shift_count=4, next_state=00; state_valid after edge T0+6.
- oxygen_ok=0 on 3 consecutive samples -> 01, 01, 11. 4th sample with all OK -> 11 (sticky). Pulse clear_abort -> next_state=00; 5th sample OK -> 00.
- Fault, fault, OK, fault samples -> 01, 01, 00, 01. The OK sample clears the counter, so no abort occurs.
- rst pulsed during SCALE while processing altitude=1023 -> next cycle state_valid=0, sample_ready=1, next_state=00, shift_count=0; no report ever issues for the discarded sample.
